// File: rtl/uart_mem_pkg.sv
// rtl/uart_mem_pkg.sv - shared state type and lane helpers for the UART memory loader
package uart_mem_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, DONE} loader_state_t;

   localparam int BYTE_W = 8;

   function automatic int bpw_of(input int data_w);
      return data_w / BYTE_W;
   endfunction

   // Byte position within a word mapped onto the memory lane it occupies.
   function automatic int lane_index(input int pos, input int bpw, input bit big_endian);
      return big_endian ? (bpw - 1 - pos) : pos;
   endfunction

endpackage

// File: rtl/byte_lane_packer.sv
// rtl/byte_lane_packer.sv - assembles received bytes into lanes of one memory word
module byte_lane_packer
   import uart_mem_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int BIG_ENDIAN = 0
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  flush,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  word_complete,
   output logic                  flush_ready,
   output logic [DATA_W-1:0]     next_word,
   output logic [DATA_W/8-1:0]   next_mask
);

   localparam int BPW = bpw_of(DATA_W);
   localparam int PW  = (BPW > 1) ? $clog2(BPW) : 1;

   logic [DATA_W-1:0] asm_q;
   logic [BPW-1:0]    mask_q;
   logic [PW-1:0]     pos_q;
   logic [PW-1:0]     lane;

   // next_word/next_mask include the byte arriving this cycle, so a completing
   // word can be written straight out without waiting for the register update.
   always_comb begin
      lane      = PW'(lane_index(int'(pos_q), BPW, BIG_ENDIAN != 0));
      next_word = asm_q;
      next_mask = mask_q;
      if (byte_valid) begin
         next_word[lane*8 +: 8] = byte_data;
         next_mask[lane]        = 1'b1;
      end
   end

   assign word_complete = byte_valid && (pos_q == PW'(BPW - 1));
   assign flush_ready   = |mask_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         asm_q  <= '0;
         mask_q <= '0;
         pos_q  <= '0;
      end else if (clear || flush || word_complete) begin
         asm_q  <= '0;
         mask_q <= '0;
         pos_q  <= '0;
      end else if (byte_valid) begin
         asm_q  <= next_word;
         mask_q <= next_mask;
         pos_q  <= pos_q + 1'b1;
      end
   end

endmodule

// File: rtl/uart_mem_loader.sv
// rtl/uart_mem_loader.sv - writes a UART byte stream into BRAM as whole or flushed partial words
module uart_mem_loader
   import uart_mem_pkg::*;
#(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 32,
   parameter int NUM_WORDS      = 96,
   parameter int BASE_ADDR      = 0,
   parameter int BIG_ENDIAN     = 0,
   parameter int TIMEOUT_CYCLES = 0
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           rx_valid,
   input  logic [7:0]                     rx_data,
   output logic                           mem_en,
   output logic [DATA_W/8-1:0]            mem_we,
   output logic [ADDR_W-1:0]              mem_addr,
   output logic [DATA_W-1:0]              mem_wdata,
   output logic                           busy,
   output logic                           done,
   output logic [$clog2(NUM_WORDS+1)-1:0] words_written,
   output logic                           overrun
);

   localparam int BPW  = bpw_of(DATA_W);
   localparam int WI_W = $clog2(NUM_WORDS + 1);

   loader_state_t state_q, state_d;

   logic              start_acc;
   logic              all_issued;
   logic              accept;
   logic              idle_expired;
   logic              timeout_hit;
   logic              write_trig;
   logic              word_complete;
   logic              flush_ready;
   logic [DATA_W-1:0] next_word;
   logic [BPW-1:0]    next_mask;
   logic [ADDR_W-1:0] addr_ptr;

   byte_lane_packer #(
      .DATA_W     (DATA_W),
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_packer (
      .clock         (clock),
      .reset         (reset),
      .clear         (start_acc),
      .flush         (timeout_hit),
      .byte_valid    (accept),
      .byte_data     (rx_data),
      .word_complete (word_complete),
      .flush_ready   (flush_ready),
      .next_word     (next_word),
      .next_mask     (next_mask)
   );

   // The idle counter expires on the cycle its count would reach TIMEOUT_CYCLES.
   generate
      if (TIMEOUT_CYCLES > 0) begin : g_timer
         localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
         logic [TW-1:0] idle_cnt;

         assign idle_expired = (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

         always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
               idle_cnt <= '0;
            end else if (state_q != LOAD || !flush_ready || rx_valid || timeout_hit) begin
               idle_cnt <= '0;
            end else begin
               idle_cnt <= idle_cnt + 1'b1;
            end
         end
      end else begin : g_no_timer
         assign idle_expired = 1'b0;
      end
   endgenerate

   always_comb begin
      start_acc   = start && (state_q != LOAD);
      all_issued  = (words_written == WI_W'(NUM_WORDS));
      accept      = (state_q == LOAD) && rx_valid && !all_issued;
      timeout_hit = (state_q == LOAD) && flush_ready && !rx_valid && idle_expired;
      write_trig  = word_complete || timeout_hit;
      state_d     = state_q;
      case (state_q)
         IDLE:    if (start) state_d = LOAD;
         LOAD:    if (mem_en && all_issued) state_d = DONE;
         DONE:    if (start) state_d = LOAD;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         mem_en        <= 1'b0;
         mem_we        <= '0;
         mem_addr      <= '0;
         mem_wdata     <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         words_written <= '0;
         overrun       <= 1'b0;
         addr_ptr      <= ADDR_W'(BASE_ADDR);
      end else begin
         state_q <= state_d;
         busy    <= (state_d == LOAD);
         done    <= (state_q == LOAD) && (state_d == DONE);
         mem_en  <= write_trig;
         mem_we  <= write_trig ? next_mask : '0;
         if (write_trig) begin
            mem_addr  <= addr_ptr;
            mem_wdata <= next_word;
         end
         if (start_acc) begin
            words_written <= '0;
            addr_ptr      <= ADDR_W'(BASE_ADDR);
            overrun       <= 1'b0;
         end else begin
            if (write_trig && !all_issued) begin
               words_written <= words_written + 1'b1;
               addr_ptr      <= addr_ptr + ADDR_W'(BPW);
            end
            if (rx_valid && state_q != LOAD) overrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb/tb_uart_mem_loader.sv - directed self-checking bench for uart_mem_loader
module tb_uart_mem_loader;

   typedef struct packed {
      logic [3:0]  we;
      logic [31:0] addr;
      logic [31:0] data;
      logic [31:0] cyc;
   } wr_t;

   logic clock;
   int   cyc;
   int   checks;
   int   failures;

   logic        reset0, start0, rx_valid0;
   logic [7:0]  rx_data0;
   logic        mem_en0, busy0, done0, overrun0;
   logic [3:0]  mem_we0;
   logic [31:0] mem_addr0, mem_wdata0;
   logic [6:0]  words_written0;

   logic        reset1, start1, rx_valid1;
   logic [7:0]  rx_data1;
   logic        mem_en1, busy1, done1, overrun1;
   logic [3:0]  mem_we1;
   logic [31:0] mem_addr1, mem_wdata1;
   logic [1:0]  words_written1;

   logic        reset2, start2, rx_valid2;
   logic [7:0]  rx_data2;
   logic        mem_en2, busy2, done2, overrun2;
   logic [3:0]  mem_we2;
   logic [31:0] mem_addr2, mem_wdata2;
   logic [2:0]  words_written2;

   wr_t q0[$];
   wr_t q1[$];
   wr_t q2[$];
   int  done_cnt0, done_cyc0, done_cnt1;

   uart_mem_loader u_dut0 (
      .clock(clock), .reset(reset0), .start(start0), .rx_valid(rx_valid0), .rx_data(rx_data0),
      .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
      .busy(busy0), .done(done0), .words_written(words_written0), .overrun(overrun0)
   );

   uart_mem_loader #(.NUM_WORDS(2), .BASE_ADDR(32'h100), .BIG_ENDIAN(1)) u_dut1 (
      .clock(clock), .reset(reset1), .start(start1), .rx_valid(rx_valid1), .rx_data(rx_data1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
      .busy(busy1), .done(done1), .words_written(words_written1), .overrun(overrun1)
   );

   uart_mem_loader #(.NUM_WORDS(4), .BASE_ADDR(32'h40), .TIMEOUT_CYCLES(5)) u_dut2 (
      .clock(clock), .reset(reset2), .start(start2), .rx_valid(rx_valid2), .rx_data(rx_data2),
      .mem_en(mem_en2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
      .busy(busy2), .done(done2), .words_written(words_written2), .overrun(overrun2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   always @(negedge clock) begin
      if (mem_en0) q0.push_back('{mem_we0, mem_addr0, mem_wdata0, cyc});
      if (mem_en1) q1.push_back('{mem_we1, mem_addr1, mem_wdata1, cyc});
      if (mem_en2) q2.push_back('{mem_we2, mem_addr2, mem_wdata2, cyc});
      if (done0) begin
         done_cnt0 = done_cnt0 + 1;
         done_cyc0 = cyc;
      end
      if (done1) done_cnt1 = done_cnt1 + 1;
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic send0(input logic [7:0] b);
      rx_valid0 = 1'b1;
      rx_data0  = b;
      tick();
      rx_valid0 = 1'b0;
   endtask

   task automatic send1(input logic [7:0] b);
      rx_valid1 = 1'b1;
      rx_data1  = b;
      tick();
      rx_valid1 = 1'b0;
   endtask

   logic [31:0] exp_data;
   logic [7:0]  be_bytes [8];
   int          t_bb;
   int          n0;

   initial begin
      checks = 0;
      failures = 0;
      done_cnt0 = 0;
      done_cyc0 = 0;
      done_cnt1 = 0;
      reset0 = 1'b1; reset1 = 1'b1; reset2 = 1'b1;
      start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
      rx_valid0 = 1'b0; rx_valid1 = 1'b0; rx_valid2 = 1'b0;
      rx_data0 = 8'h00; rx_data1 = 8'h00; rx_data2 = 8'h00;
      repeat (3) tick();

      check("rst_mem_en",   mem_en0, 0);
      check("rst_mem_we",   mem_we0, 0);
      check("rst_mem_addr", mem_addr0, 0);
      check("rst_wdata",    mem_wdata0, 0);
      check("rst_busy",     busy0, 0);
      check("rst_done",     done0, 0);
      check("rst_words",    words_written0, 0);
      check("rst_overrun",  overrun0, 0);

      reset0 = 1'b0; reset1 = 1'b0; reset2 = 1'b0;
      tick();

      // Full default load, one byte every cycle, bytes 0x00..0xFF repeating.
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      check("busy_after_start", busy0, 1);
      for (int i = 0; i < 384; i++) send0(8'(i));
      repeat (4) tick();

      check("n_writes", q0.size(), 96);
      if (q0.size() == 96) begin
         check("first_addr", q0[0].addr, 32'h0);
         check("first_data", q0[0].data, 32'h03020100);
         check("second_data", q0[1].data, 32'h07060504);
         check("last_addr", q0[95].addr, 32'h17C);
         check("last_data", q0[95].data, 32'h7F7E7D7C);
         check("done_latency", done_cyc0, q0[95].cyc + 1);
         for (int k = 0; k < 96; k++) begin
            exp_data = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
            check($sformatf("wr%0d_addr", k), q0[k].addr, 32'(4*k));
            check($sformatf("wr%0d_data", k), q0[k].data, exp_data);
            check($sformatf("wr%0d_we", k), q0[k].we, 4'hF);
         end
      end
      check("done_count", done_cnt0, 1);
      check("words_96", words_written0, 96);
      check("busy_done", busy0, 0);

      // Byte in DONE is dropped and flags overrun.
      n0 = q0.size();
      send0(8'h55);
      check("ovr_done", overrun0, 1);
      tick();
      check("drop_done", q0.size(), n0);

      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      check("ovr_clear", overrun0, 0);
      check("words_clear", words_written0, 0);
      check("busy_reload", busy0, 1);
      q0.delete();
      send0(8'hDE); send0(8'hAD); send0(8'hBE); send0(8'hEF);
      repeat (2) tick();
      check("reload_n", q0.size(), 1);
      if (q0.size() == 1) begin
         check("reload_addr", q0[0].addr, 32'h0);
         check("reload_data", q0[0].data, 32'hEFBEADDE);
      end

      // Reset in the middle of a word discards it.
      q0.delete();
      send0(8'hA1); send0(8'hA2);
      reset0 = 1'b1;
      #1;
      check("mrst_mem_en", mem_en0, 0);
      check("mrst_wdata",  mem_wdata0, 0);
      check("mrst_addr",   mem_addr0, 0);
      check("mrst_busy",   busy0, 0);
      check("mrst_words",  words_written0, 0);
      tick();
      reset0 = 1'b0;
      tick();
      check("mrst_no_write", q0.size(), 0);
      send0(8'h99);
      check("ovr_idle", overrun0, 1);
      tick();
      check("drop_idle", q0.size(), 0);
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      check("ovr_idle_clear", overrun0, 0);
      send0(8'h01); send0(8'h02); send0(8'h03); send0(8'h04);
      repeat (2) tick();
      check("post_rst_n", q0.size(), 1);
      if (q0.size() == 1) begin
         check("post_rst_addr", q0[0].addr, 32'h0);
         check("post_rst_data", q0[0].data, 32'h04030201);
      end

      // Big-endian, two words from base 0x100.
      be_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      for (int i = 0; i < 8; i++) send1(be_bytes[i]);
      repeat (4) tick();
      check("be_n", q1.size(), 2);
      if (q1.size() == 2) begin
         check("be0_addr", q1[0].addr, 32'h100);
         check("be0_data", q1[0].data, 32'h11223344);
         check("be0_we",   q1[0].we, 4'hF);
         check("be1_addr", q1[1].addr, 32'h104);
         check("be1_data", q1[1].data, 32'h55667788);
      end
      check("be_done", done_cnt1, 1);
      check("be_words", words_written1, 2);

      // Timeout flush of a two-byte partial word.
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      rx_valid2 = 1'b1;
      rx_data2 = 8'hAA;
      tick();
      rx_data2 = 8'hBB;
      t_bb = cyc;
      tick();
      rx_valid2 = 1'b0;
      repeat (4) tick();
      check("no_early_flush", q2.size(), 0);
      repeat (2) tick();
      check("flush_n", q2.size(), 1);
      if (q2.size() == 1) begin
         check("flush_cyc",  q2[0].cyc, t_bb + 6);
         check("flush_we",   q2[0].we, 4'h3);
         check("flush_data", q2[0].data, 32'h0000BBAA);
         check("flush_addr", q2[0].addr, 32'h40);
      end
      check("flush_words", words_written2, 1);

      // A byte on the expiry cycle wins over the flush.
      q2.delete();
      rx_valid2 = 1'b1;
      rx_data2 = 8'hCC;
      tick();
      rx_valid2 = 1'b0;
      repeat (4) tick();
      rx_valid2 = 1'b1;
      rx_data2 = 8'hDD;
      tick();
      rx_valid2 = 1'b0;
      repeat (8) tick();
      check("supp_n", q2.size(), 1);
      if (q2.size() == 1) begin
         check("supp_we",   q2[0].we, 4'h3);
         check("supp_data", q2[0].data, 32'h0000DDCC);
         check("supp_addr", q2[0].addr, 32'h44);
      end
      check("supp_words", words_written2, 2);
      check("supp_busy", busy2, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
Parametrised byte-stream-to-memory loader. It assembles bytes from the UART receiver into DATA_W-bit words, then writes each completed word to a BRAM port as one full-word strobe. Supports a configurable word count, base address, byte order, partial-word flush on idle timeout, restart without reset, and overrun reporting. It sits between the UART RX block and port A of the program/data BRAM.

Parameters:
DATA_W, 32, memory word width in bits; multiple of 8, range 8..128; BPW = DATA_W/8 lanes
ADDR_W, 32, byte-address width of mem_addr
NUM_WORDS, 96, words to write before completion; must be at least 1
BASE_ADDR, 0, byte address of the first word; must be BPW-aligned
BIG_ENDIAN, 0, 0: first byte goes to lane 0 (LSB); 1: first byte goes to lane BPW-1
TIMEOUT_CYCLES, 0, idle cycles before a partial word is flushed; 0 disables flushing

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
start  in  1  one-cycle pulse; begins a load from IDLE or DONE
rx_valid  in  1  one-cycle strobe; rx_data is valid
rx_data  in  8  received byte
mem_en  out  1  memory enable; high only in a write cycle
mem_we  out  BPW  per-lane write enable
mem_addr  out  ADDR_W  byte address of the write
mem_wdata  out  DATA_W  write data
busy  out  1  high while in LOAD
done  out  1  one-cycle pulse on entry to DONE
words_written  out  $clog2(NUM_WORDS+1)  count of words issued since the last start
overrun  out  1  sticky; a byte arrived outside LOAD

Behaviour:
- Reset (asynchronous):
  - state = IDLE.
  - All outputs = 0.
  - Lane pointer, assembly register, lane-filled mask, word index and idle counter = 0.
- States:
  - IDLE: start -> LOAD; counters cleared.
  - LOAD: rx_valid accepts rx_data into lane L.
    - L = pos when BIG_ENDIAN=0; L = BPW-1-pos when BIG_ENDIAN=1.
    - pos increments and the lane is marked filled.
  - DONE: start -> LOAD with words_written, pos, mask and overrun cleared. Otherwise DONE holds.
  - There is no other exit from DONE.
- Full-word write:
  - Trigger: the cycle that accepts the byte at pos = BPW-1.
  - Next cycle (registered outputs, latency 1):
    - mem_en = 1 and mem_we = all ones.
    - mem_wdata = the assembled word, including the last byte.
    - mem_addr = BASE_ADDR + word_idx*BPW, truncated to ADDR_W.
  - In the trigger cycle, pos, mask and the assembly register clear and word_idx increments.
  - A byte arriving in the write cycle is accepted into the fresh word; no byte is dropped.
- Partial flush:
  - Applies only when TIMEOUT_CYCLES > 0 and pos != 0.
  - The idle counter increments on each cycle without rx_valid and resets on rx_valid.
  - When the count reaches TIMEOUT_CYCLES, a write is issued the next cycle:
    - mem_we = filled mask.
    - Unfilled lanes of mem_wdata = 0.
  - pos and mask clear and word_idx increments, as for a full word.
  - If rx_valid arrives in the same cycle the count would expire, the byte wins and there is no flush.
- Completion:
  - When a write is issued with word_idx reaching NUM_WORDS, the FSM moves LOAD -> DONE in the cycle after that write.
  - done = 1 for exactly that one cycle; busy falls in the same cycle.
- words_written:
  - Increments in each write cycle.
  - Saturates at NUM_WORDS.
- Outside LOAD:
  - rx_valid in IDLE or DONE: the byte is dropped and overrun sets.
  - overrun clears only on an accepted start.
- start in LOAD: ignored.
- Mid-operation reset: the partial word is discarded and no write is issued.
- mem_en/mem_we are never asserted outside a write cycle.

Decomposition:
- Package uart_mem_pkg:
  - loader_state_t enum {IDLE, LOAD, DONE}.
  - A lane_index(pos, big_endian) function.
  - A BPW-derivation helper constant.
- Sub-module byte_lane_packer (DATA_W, BIG_ENDIAN). It owns:
  - the assembly register, lane pointer and filled mask;
  - the word_complete and flush-request outputs.
- The top level owns the FSM, address/word counters, idle timer and output registers.

Test Plan:
- Defaults, start, then 384 bytes 0x00..0xFF,0x00..: 96 writes, each with mem_we=0xF.
  - First write: addr 0x0, data 0x03020100.
  - Last write: addr 0x17C.
  - done pulses once, one cycle after the last write; words_written=96.
- BIG_ENDIAN=1, NUM_WORDS=2, bytes 11 22 33 44 55 66 77 88 -> data 0x11223344 at addr BASE_ADDR, then 0x55667788 at BASE_ADDR+4.
- TIMEOUT_CYCLES=5, NUM_WORDS=4, bytes AA BB, then silence -> flush 5 cycles after the last idle count starts: mem_we=0x3, mem_wdata=0x0000BBAA.
  - words_written=1.
  - A byte on the expiry cycle suppresses the flush.
- Back-to-back bytes every cycle -> a byte arriving in the write cycle lands at lane 0 of the next word; no loss.
- rx_valid in IDLE and in DONE -> no mem_en, overrun=1.
  - A start then clears overrun and words_written.
  - The reload rewrites from BASE_ADDR.
- Reset asserted after 2 bytes of a word -> no write; all outputs 0; the next start begins at BASE_ADDR, lane 0.
